// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package display_pkg;

  typedef enum logic {
    GUARD_S = 1'b0,
    DRIVE_S = 1'b1
  } scan_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Decoder maps this code to all segments off.
  localparam bcd_digit_t BLANK_CODE = 4'hF;

endpackage

// File: rtl/display_scan_controller_if.sv
// Datapath-facing load port and display-facing scan outputs of display_scan_controller.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  import display_pkg::*;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  bcd_digit_t              bcd;
  logic [NUM_DIGITS-1:0]   digit_en_L;
  logic                    update_pending;

  modport master (
    output load, digits_in,
    input  bcd, digit_en_L, update_pending
  );

  modport slave (
    input  load, digits_in,
    output bcd, digit_en_L, update_pending
  );

endinterface

// File: rtl/scan_timer.sv
// Dwell/guard interval counter; expire pulses on the last cycle of the current phase.
module scan_timer
  import display_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int GUARD = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  scan_state_t state,
  output logic        expire
);

  localparam int MAX_CNT = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  logic [CW-1:0] cnt_r;

  // Terminal-count detect for whichever phase is running.
  always_comb begin
    expire = 1'b0;
    case (state)
      GUARD_S: expire = (cnt_r == GUARD_LAST);
      DRIVE_S: expire = (cnt_r == DWELL_LAST);
      default: expire = 1'b0;
    endcase
  end

  // Phase counter restarts from zero on every expiry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (expire) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Double-buffered BCD digit scanner feeding one shared seven-segment decoder.
// Optional leading-zero blanking: define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GUARD      = 16
) (
  input logic                      clock,
  input logic                      reset,
  display_scan_controller_if.slave bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t           state_r, nxt_state_s;
  logic [IW-1:0]         idx_r, nxt_idx_s;
  logic [DW-1:0]         active_r, nxt_active_s, pending_r;
  logic                  pending_valid_r;
  logic                  expire_s, boundary_s;
  bcd_digit_t            bcd_r, nxt_bcd_s;
  logic [NUM_DIGITS-1:0] en_r, nxt_en_s, blank_vec_s;
  int                    sel_s;

  scan_timer #(
    .DWELL (DWELL),
    .GUARD (GUARD)
  ) u_scan_timer (
    .clock  (clock),
    .reset  (reset),
    .state  (state_r),
    .expire (expire_s)
  );

  // Next scan position; the idx wrap is the frame boundary where pending data is promoted.
  always_comb begin
    nxt_state_s = state_r;
    nxt_idx_s   = idx_r;
    boundary_s  = 1'b0;
    case (state_r)
      GUARD_S: begin
        if (expire_s) begin
          nxt_state_s = DRIVE_S;
          if (idx_r == LAST_IDX) begin
            nxt_idx_s  = {IW{1'b0}};
            boundary_s = 1'b1;
          end else begin
            nxt_idx_s = idx_r + IW'(1);
          end
        end else begin
          nxt_state_s = GUARD_S;
        end
      end
      DRIVE_S: begin
        if (expire_s) begin
          nxt_state_s = GUARD_S;
        end else begin
          nxt_state_s = DRIVE_S;
        end
      end
      default: nxt_state_s = GUARD_S;
    endcase
    nxt_active_s = (boundary_s && pending_valid_r) ? pending_r : active_r;
  end

  // Output decode from next-state values so the registered outputs line up with the scan state.
  always_comb begin
    blank_vec_s = {NUM_DIGITS{1'b0}};
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        zero_above     = zero_above & (nxt_active_s[4*i +: 4] == 4'h0);
        blank_vec_s[i] = zero_above & (i != 0);
      end
    end
`endif
    sel_s     = int'(nxt_idx_s);
    nxt_bcd_s = BLANK_CODE;
    nxt_en_s  = {NUM_DIGITS{1'b1}};
    if ((nxt_state_s == DRIVE_S) && !blank_vec_s[nxt_idx_s]) begin
      nxt_bcd_s           = nxt_active_s[4*sel_s +: 4];
      nxt_en_s[nxt_idx_s] = 1'b0;
    end else begin
      nxt_bcd_s = BLANK_CODE;
      nxt_en_s  = {NUM_DIGITS{1'b1}};
    end
  end

  // Scan FSM, display buffers and registered pin drivers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= GUARD_S;
      idx_r           <= LAST_IDX;
      active_r        <= {DW{1'b0}};
      pending_r       <= {DW{1'b0}};
      pending_valid_r <= 1'b0;
      bcd_r           <= BLANK_CODE;
      en_r            <= {NUM_DIGITS{1'b1}};
    end else begin
      state_r  <= nxt_state_s;
      idx_r    <= nxt_idx_s;
      active_r <= nxt_active_s;
      bcd_r    <= nxt_bcd_s;
      en_r     <= nxt_en_s;
      // A load coinciding with the boundary refills pending after the old value moves to active.
      if (bus.load) begin
        pending_r       <= bus.digits_in;
        pending_valid_r <= 1'b1;
      end else if (boundary_s) begin
        pending_valid_r <= 1'b0;
      end else begin
        pending_valid_r <= pending_valid_r;
      end
    end
  end

  assign bus.bcd            = bcd_r;
  assign bus.digit_en_L     = en_r;
  assign bus.update_pending = pending_valid_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with NUM_DIGITS=4, DWELL=4, GUARD=1.
module tb_display_scan_controller;

  logic clock;
  logic reset;

  display_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  display_scan_controller #(
    .NUM_DIGITS (4),
    .DWELL      (4),
    .GUARD      (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [15:0] exp_disp = 16'h0000;
  logic [15:0] exp_pend = 16'h0000;
  logic        exp_pv   = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %h expected %h", tag, k, obs, exp);
    end
  endtask

  // One clock with optional load, then compare against the spec schedule (period 5, frame 20).
  task automatic cyc(input logic ld, input logic [15:0] din);
    logic [3:0] e_en;
    logic [3:0] e_bcd;
    int p;
    int d;
    bus.load      = ld;
    bus.digits_in = din;
    @(posedge clock);
    #1;
    k++;
    bus.load      = 1'b0;
    bus.digits_in = 16'h0000;
    if ((k % 20) == 1) begin
      if (exp_pv) exp_disp = exp_pend;
      exp_pv = 1'b0;
    end
    if (ld) begin
      exp_pend = din;
      exp_pv   = 1'b1;
    end
    p = (k - 1) % 20;
    d = p / 5;
    if ((p % 5) == 4) begin
      e_en  = 4'hF;
      e_bcd = 4'hF;
    end else begin
      e_en  = ~(4'b0001 << d);
      e_bcd = exp_disp[4*d +: 4];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      if ((d > 0) && ((exp_disp >> (4*d)) == 16'h0000)) begin
        e_en  = 4'hF;
        e_bcd = 4'hF;
      end
`endif
    end
    check("digit_en_L", {12'h000, bus.digit_en_L}, {12'h000, e_en});
    check("bcd", {12'h000, bus.bcd}, {12'h000, e_bcd});
    check("update_pending", {15'h0000, bus.update_pending}, {15'h0000, exp_pv});
  endtask

  task automatic run_to(input int target);
    while (k < target) cyc(1'b0, 16'h0000);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #5;
    reset    = 1'b0;
    k        = 0;
    exp_disp = 16'h0000;
    exp_pend = 16'h0000;
    exp_pv   = 1'b0;
    #1;
    check("rst_en", {12'h000, bus.digit_en_L}, 16'h000F);
    check("rst_bcd", {12'h000, bus.bcd}, 16'h000F);
    check("rst_up", {15'h0000, bus.update_pending}, 16'h0000);
  endtask

  initial begin
    reset         = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = 16'h0000;
    @(posedge clock);
    release_reset();

    // Idle scan of zeros.
    run_to(25);

    // Mid-frame load, shown from the boundary at k=41.
    cyc(1'b1, 16'h1234);
    run_to(61);

    // Two loads in one frame: last wins.
    cyc(1'b0, 16'h0000);
    cyc(1'b1, 16'h1111);
    run_to(69);
    cyc(1'b1, 16'h2222);
    run_to(101);

    // Load exactly on the boundary edge (k=121) while 0009 is pending.
    run_to(109);
    cyc(1'b1, 16'h0009);
    run_to(120);
    cyc(1'b1, 16'h5678);
    check("boundary_load_up", {15'h0000, bus.update_pending}, 16'h0001);
    check("boundary_load_d0", {12'h000, bus.bcd}, 16'h0009);
    run_to(145);

    // Reset during digit 2 drive with data pending.
    run_to(146);
    cyc(1'b1, 16'h4321);
    run_to(152);
    check("pre_rst_en", {12'h000, bus.digit_en_L}, 16'h000B);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_en", {12'h000, bus.digit_en_L}, 16'h000F);
    check("async_rst_bcd", {12'h000, bus.bcd}, 16'h000F);
    check("async_rst_up", {15'h0000, bus.update_pending}, 16'h0000);
    release_reset();
    run_to(45);

    // Leading-zero patterns (blanked only when the option is built in).
    cyc(1'b1, 16'h0040);
    run_to(81);
    cyc(1'b1, 16'h0000);
    run_to(101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexes a single shared BCD-to-seven-segment decoder across `NUM_DIGITS` common-anode digits. The block holds a double-buffered multi-digit BCD value. It scans one digit at a time, feeding that digit's BCD code to the decoder and driving the matching active-low digit enable, with a guard interval between digits to suppress ghosting. It sits between the datapath that produces BCD results and the decoder/display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; range 2–8.
- `DWELL`, 1000: clock cycles each digit is driven; at least 1.
- `GUARD`, 16: clock cycles all digits are off between digits; at least 1.
- `clock` input 1: single clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `load` input 1: one-cycle request to capture `digits_in`.
- `digits_in` input 4*NUM_DIGITS: BCD digits; digit 0 is the least significant, in bits [3:0].
- `bcd` output 4: code to the shared decoder; 4'hF when blanked (decoder default gives all segments off).
- `digit_en_L` output NUM_DIGITS: active-low digit enables; at most one bit low at any time.
- `update_pending` output 1: high while loaded data waits for the frame boundary.

## Operation
- Registers:
  - `active` (displayed value).
  - `pending` plus `pending_valid`.
  - `idx` (0..NUM_DIGITS-1).
  - `cnt` (dwell/guard counter, width clog2(max(DWELL,GUARD))).
  - `state` ∈ {GUARD_S, DRIVE_S}.
- GUARD_S:
  - `digit_en_L` all 1; `bcd` = 4'hF.
  - `cnt` counts 0..GUARD-1.
  - At GUARD-1: `idx` advances to (idx+1) mod NUM_DIGITS; `cnt` ← 0; state → DRIVE_S.
- DRIVE_S:
  - `digit_en_L[idx]` = 0; `bcd` = `active[idx]`.
  - `cnt` counts 0..DWELL-1, then `cnt` ← 0 and state → GUARD_S.
- Frame boundary:
  - Occurs on the GUARD_S→DRIVE_S transition where `idx` wraps from NUM_DIGITS-1 to 0.
  - If `pending_valid`: `active` ← `pending` and `pending_valid` ← 0 on the same edge.
- Load behaviour:
  - `load` writes `pending` ← `digits_in` and sets `pending_valid`. A later load before the boundary overwrites (last wins).
  - Load on the boundary cycle: `active` takes the old `pending` if it was valid, otherwise `active` is unchanged. `pending` takes the new data, and `pending_valid` stays 1.
- Non-BCD digit codes (A–F) pass through unchanged; the decoder blanks them.
- `update_pending` = `pending_valid`.

## Timing
- Reset values: `state` GUARD_S, `idx` NUM_DIGITS-1, `cnt` 0, `active` all 0, `pending` 0, `pending_valid` 0.
- Reset output values: `digit_en_L` all 1, `bcd` 4'hF, `update_pending` 0.
- All outputs decode from registers only; there is no combinational path from `load` or `digits_in` to any output.
- Scan after reset:
  - First DRIVE_S (digit 0) starts GUARD cycles after reset deassertion.
  - Each digit period is DWELL+GUARD cycles.
  - A frame is NUM_DIGITS*(DWELL+GUARD) cycles.
- Load-to-display latency: load in cycle t shows at the next frame boundary after t. Worst case is one frame plus one cycle.
- Reset asserted mid-scan: enables go all high immediately (asynchronous), and pending data is discarded.

## Configuration
- Macro: `DISPLAY_LEADING_ZERO_BLANK_EN`.
- Defined:
  - In DRIVE_S, digit i > 0 outputs `bcd` = 4'hF and keeps `digit_en_L[i]` = 1 when `active[i]` and all higher digits equal 0.
  - Digit 0 is never blanked.
  - Scan timing is unchanged.
- Undefined: every digit is shown, including leading zeros.

## Structure
- Package `display_pkg`:
  - `scan_state_t` enum {GUARD_S, DRIVE_S}.
  - `BLANK_CODE` = 4'hF.
  - `bcd_digit_t` = logic [3:0].
- Sub-module `scan_timer`: parameterised dwell/guard counter emitting a one-cycle `expire` pulse. The FSM, buffers and output decode stay in the top.
- The shared decoder is instantiated one level up, not inside this block.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL=4, GUARD=1.
1. Reset then idle 25 cycles → `digit_en_L` steps 1110, 1101, 1011, 0111, each low for 4 cycles with a 1-cycle 1111 gap. `bcd` = 0 while driven and F in gaps.
2. `load` with `digits_in`=16'h1234 mid-frame → `update_pending`=1 until the next boundary. Then digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1.
3. Two loads (16'h1111 then 16'h2222) within one frame → only 16'h2222 is displayed; 16'h1111 never appears.
4. `load` of 16'h5678 exactly on the boundary cycle while pending holds 16'h0009 → this frame shows 0009; `update_pending` stays 1; the next frame shows 5678.
5. Assert `reset` during DRIVE_S of digit 2 → `digit_en_L`=1111 and `bcd`=F in the same cycle. After release, scanning restarts from digit 0 with `active`=0.
6. With `DISPLAY_LEADING_ZERO_BLANK_EN`, load 16'h0040 → digits 3 and 2 stay off; digit 1 shows 4; digit 0 shows 0. Loading 16'h0000 shows only digit 0.
